// File: rtl/modul_arbiter_pkg.sv
// Shared types and constants for the round-robin DUT-sharing arbiter.
package modul_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int NREQ_DEF = 4;
  localparam int HOLD_DEF = 2;
  // Hold counter width; HOLD must stay within 1..15 to fit
  localparam int CNT_W    = 4;

  // Index width for NREQ requesters, never less than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/modul_arbiter_if.sv
// Requester/DUT-side bundle of the arbiter. The arbiter uses the slave
// view; whoever owns the requesters and the shared DUT uses master.
interface modul_arbiter_if
  import modul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_in;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rsp_valid;
  logic            rsp_data;
  logic            busy;
  logic            dut_in;
  logic            dut_out;

  modport master (
    output req, req_in, dut_out,
    input  gnt, rsp_valid, rsp_data, busy, dut_in
  );

  modport slave (
    input  req, req_in, dut_out,
    output gnt, rsp_valid, rsp_data, busy, dut_in
  );

endinterface

// File: rtl/modul_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] winner_idx
);

  // Scan ptr+1, ptr+2, ... ptr+NREQ (mod NREQ); the last winner comes last
  always_comb begin
    logic             found;
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    winner     = '0;
    winner_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(ptr) + i) % NREQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        winner[cand_idx] = 1'b1;
        winner_idx      = cand_idx;
      end
    end
  end

endmodule

// File: rtl/modul_arbiter.sv
// Round-robin arbiter sharing one 1-bit DUT among NREQ requesters:
// grant, hold the stimulus HOLD cycles, sample the DUT, strobe the answer.
module modul_arbiter
  import modul_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input logic           clk,
  input logic           rst,
  modul_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NREQ);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic             rsp_data_q, rsp_data_d;
  logic             dut_in_q, dut_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req        (bus.req),
    .ptr        (ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx)
  );

  // Next-state and output decode; an aborted or reset transaction never strobes
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    dut_in_d    = dut_in_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    case (state_q)
      IDLE: begin
        gnt_d    = '0;
        dut_in_d = 1'b0;
        if (|bus.req) begin
          gnt_d    = pick_onehot;
          win_d    = pick_idx;
          dut_in_d = bus.req_in[pick_idx];
          cnt_d    = CNT_W'(HOLD - 1);
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (!bus.req[win_q]) begin
          gnt_d    = '0;
          dut_in_d = 1'b0;
          cnt_d    = '0;
          ptr_d    = win_q;
          state_d  = IDLE;
        end else if (cnt_q == '0) begin
          rsp_data_d  = bus.dut_out;
          rsp_valid_d = gnt_q;
          gnt_d       = '0;
          dut_in_d    = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: begin
        gnt_d    = '0;
        dut_in_d = 1'b0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // State register; ptr resets to the top index so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 1'b0;
      dut_in_q    <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= IDX_W'(NREQ - 1);
      win_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      dut_in_q    <= dut_in_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_modul_arbiter.sv
// Directed bench for modul_arbiter: one HOLD=2 and one HOLD=1 instance,
// each with an inverter as the shared DUT and a response scoreboard.
module tb_modul_arbiter;
  import modul_arb_pkg::*;

  typedef struct {
    int   idx;
    logic data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] ri_v;

  // Free-running 10 ns clock
  always #5 clk = ~clk;

  modul_arbiter_if #(.NREQ(4)) if_a ();
  modul_arbiter_if #(.NREQ(4)) if_b ();

  assign if_a.dut_out = ~if_a.dut_in;
  assign if_b.dut_out = ~if_b.dut_in;

  modul_arbiter #(.NREQ(4), .HOLD(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  modul_arbiter #(.NREQ(4), .HOLD(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [3:0] r, input logic [3:0] ri);
    if (sel == 0) begin
      if_a.req    = r;
      if_a.req_in = ri;
    end else begin
      if_b.req    = r;
      if_b.req_in = ri;
    end
  endtask

  task automatic expectRsp(input int sel, input int idx, input logic data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    if (sel == 0) sb_a.push_back(e);
    else          sb_b.push_back(e);
  endtask

  task automatic checkResp(input int sel);
    logic [3:0] rv;
    logic [3:0] g;
    logic       rd;
    logic       has;
    exp_t       e;
    string      n;
    has    = 1'b0;
    e.idx  = 0;
    e.data = 1'b0;
    if (sel == 0) begin
      rv = if_a.rsp_valid; g = if_a.gnt; rd = if_a.rsp_data; n = "a";
    end else begin
      rv = if_b.rsp_valid; g = if_b.gnt; rd = if_b.rsp_data; n = "b";
    end
    checkOutput({n, " gnt/rsp_valid overlap"}, 32'(g & rv), 32'h0);
    if (rv !== 4'b0000) begin
      if (sel == 0 && sb_a.size() > 0) begin
        has = 1'b1; e = sb_a.pop_front();
      end else if (sel == 1 && sb_b.size() > 0) begin
        has = 1'b1; e = sb_b.pop_front();
      end
      if (!has) begin
        checkOutput({n, " unexpected rsp_valid"}, 32'(rv), 32'h0);
      end else begin
        checkOutput({n, " rsp_valid"}, 32'(rv), 32'h1 << e.idx);
        checkOutput({n, " rsp_data"}, 32'(rd), 32'(e.data));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkResp(0);
    checkResp(1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 4'b0000, 4'b0000);
    applyStimulus(1, 4'b0000, 4'b0000);
    step();
    step();
    rst = 1'b0;
    checkOutput("reset gnt",       32'(if_a.gnt),       32'h0);
    checkOutput("reset rsp_valid", 32'(if_a.rsp_valid), 32'h0);
    checkOutput("reset rsp_data",  32'(if_a.rsp_data),  32'h0);
    checkOutput("reset dut_in",    32'(if_a.dut_in),    32'h0);
    checkOutput("reset busy",      32'(if_a.busy),      32'h0);
    checkOutput("reset b busy",    32'(if_b.busy),      32'h0);

    $display("[TB] single request, HOLD=2");
    applyStimulus(0, 4'b0001, 4'b0001);
    expectRsp(0, 0, 1'b0);
    step();
    checkOutput("single t1 gnt",    32'(if_a.gnt),    32'h1);
    checkOutput("single t1 dut_in", 32'(if_a.dut_in), 32'h1);
    checkOutput("single t1 busy",   32'(if_a.busy),   32'h1);
    applyStimulus(0, 4'b0001, 4'b0000);
    step();
    checkOutput("single t2 gnt",    32'(if_a.gnt),    32'h1);
    checkOutput("single t2 dut_in", 32'(if_a.dut_in), 32'h1);
    step();
    checkOutput("single t3 rsp_valid", 32'(if_a.rsp_valid), 32'h1);
    checkOutput("single t3 gnt",       32'(if_a.gnt),       32'h0);
    checkOutput("single sb drained",   32'(sb_a.size()),    32'h0);
    applyStimulus(0, 4'b0000, 4'b0000);
    step();
    checkOutput("single t4 busy",      32'(if_a.busy),      32'h0);
    checkOutput("single t4 rsp_valid", 32'(if_a.rsp_valid), 32'h0);
    checkOutput("single t4 dut_in",    32'(if_a.dut_in),    32'h0);

    $display("[TB] all four requesting from reset");
    rst = 1'b1;
    step();
    rst = 1'b0;
    ri_v = 4'b0101;
    applyStimulus(0, 4'b1111, ri_v);
    for (int k = 0; k < 5; k++) expectRsp(0, order[k], ~ri_v[order[k]]);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("rotation gnt", 32'(if_a.gnt), 32'h1 << order[k]);
      step();
      step();
      checkOutput("rotation rsp_valid", 32'(if_a.rsp_valid), 32'h1 << order[k]);
      step();
      checkOutput("rotation idle rsp_valid", 32'(if_a.rsp_valid), 32'h0);
      checkOutput("rotation idle busy",      32'(if_a.busy),      32'h0);
      if (k == 4) applyStimulus(0, 4'b0000, 4'b0000);
    end
    checkOutput("rotation sb drained", 32'(sb_a.size()), 32'h0);

    $display("[TB] abort of requester 2");
    applyStimulus(0, 4'b0100, 4'b0000);
    step();
    checkOutput("abort drive gnt", 32'(if_a.gnt), 32'h4);
    applyStimulus(0, 4'b0000, 4'b0000);
    step();
    checkOutput("abort gnt",    32'(if_a.gnt),    32'h0);
    checkOutput("abort busy",   32'(if_a.busy),   32'h0);
    checkOutput("abort dut_in", 32'(if_a.dut_in), 32'h0);
    applyStimulus(0, 4'b1100, 4'b0000);
    expectRsp(0, 3, 1'b1);
    step();
    checkOutput("abort next gnt", 32'(if_a.gnt), 32'h8);
    step();
    step();
    checkOutput("abort next rsp_valid", 32'(if_a.rsp_valid), 32'h8);
    applyStimulus(0, 4'b0000, 4'b0000);
    step();
    checkOutput("rsp_data held",     32'(if_a.rsp_data), 32'h1);
    checkOutput("abort sb drained",  32'(sb_a.size()),   32'h0);

    $display("[TB] reset during DRIVE");
    applyStimulus(0, 4'b0010, 4'b0010);
    step();
    checkOutput("mid-reset t1 gnt", 32'(if_a.gnt), 32'h2);
    step();
    rst = 1'b1;
    step();
    checkOutput("mid-reset gnt",       32'(if_a.gnt),       32'h0);
    checkOutput("mid-reset rsp_valid", 32'(if_a.rsp_valid), 32'h0);
    checkOutput("mid-reset dut_in",    32'(if_a.dut_in),    32'h0);
    checkOutput("mid-reset busy",      32'(if_a.busy),      32'h0);
    checkOutput("mid-reset rsp_data",  32'(if_a.rsp_data),  32'h0);
    rst = 1'b0;
    applyStimulus(0, 4'b1111, 4'b1111);
    expectRsp(0, 0, 1'b0);
    step();
    checkOutput("post-reset gnt", 32'(if_a.gnt), 32'h1);
    step();
    step();
    applyStimulus(0, 4'b0000, 4'b0000);
    step();
    checkOutput("post-reset sb drained", 32'(sb_a.size()), 32'h0);

    $display("[TB] HOLD=1 with req_in toggling");
    applyStimulus(1, 4'b0100, 4'b0100);
    expectRsp(1, 2, 1'b0);
    step();
    checkOutput("h1 gnt",    32'(if_b.gnt),    32'h4);
    checkOutput("h1 dut_in", 32'(if_b.dut_in), 32'h1);
    applyStimulus(1, 4'b0100, 4'b1011);
    step();
    checkOutput("h1 rsp_valid", 32'(if_b.rsp_valid), 32'h4);
    checkOutput("h1 rsp_data",  32'(if_b.rsp_data),  32'h0);
    applyStimulus(1, 4'b0000, 4'b0000);
    step();
    checkOutput("h1 idle busy", 32'(if_b.busy), 32'h0);
    applyStimulus(1, 4'b0001, 4'b0000);
    expectRsp(1, 0, 1'b1);
    step();
    checkOutput("h1 second gnt",    32'(if_b.gnt),    32'h1);
    checkOutput("h1 second dut_in", 32'(if_b.dut_in), 32'h0);
    applyStimulus(1, 4'b0001, 4'b1111);
    step();
    checkOutput("h1 second rsp_data", 32'(if_b.rsp_data), 32'h1);
    applyStimulus(1, 4'b0000, 4'b0000);
    step();
    checkOutput("h1 sb drained", 32'(sb_b.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modul_arbiter.md
MODUL_ARBITER -- requirements
Module: modul_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the 1-bit DUT.
REQ-002 Parameter HOLD, default 2: cycles dut_in is held stable before dut_out is sampled; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port req  input  NREQ  per-requester request; level, held until rsp_valid bit or abort.
REQ-006 Port req_in  input  NREQ  per-requester stimulus bit to apply to the DUT.
REQ-007 Port gnt  output  NREQ  one-hot grant; all-zero when no transaction is in DRIVE.
REQ-008 Port dut_in  output  1  registered stimulus to the shared DUT input.
REQ-009 Port dut_out  input  1  shared DUT output, sampled by the arbiter.
REQ-010 Port rsp_valid  output  NREQ  one-cycle, one-hot response strobe to the served requester.
REQ-011 Port rsp_data  output  1  sampled dut_out; valid when any rsp_valid bit is high, then held until the next sample.
REQ-012 Port busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE and RESP.
REQ-014 In IDLE with req nonzero, the arbiter SHALL select a winner round-robin, searching from ptr+1 upward with wrap-around; ptr is the index of the last winner.
REQ-015 On selection, the arbiter SHALL register gnt[winner]=1, latch dut_in=req_in[winner], load cnt=HOLD-1, and enter DRIVE.
REQ-016 In DRIVE, gnt and dut_in SHALL hold constant, and changes on req_in SHALL be ignored.
REQ-017 In DRIVE, cnt SHALL decrement each cycle; at cnt==0 the arbiter SHALL capture dut_out into rsp_data, clear gnt, and enter RESP.
REQ-018 In RESP, rsp_valid[winner] SHALL be 1 for exactly one cycle; ptr SHALL update to the winner; next state is IDLE.
REQ-019 Latency: req seen in IDLE at cycle t gives gnt high during t+1..t+HOLD and rsp_valid at t+HOLD+1; minimum request-to-request turnaround is HOLD+2 cycles.
REQ-020 In IDLE, dut_in SHALL be 0 and gnt SHALL be 0.
REQ-021 Abort: if req[winner] drops during DRIVE, the arbiter SHALL clear gnt, return to IDLE next cycle, emit no rsp_valid, and still advance ptr to the winner.
REQ-022 New requests arriving during DRIVE or RESP SHALL wait and are arbitrated only in IDLE.
REQ-023 Simultaneous requests: all requesters asserting continuously SHALL be served in strict rotation, so no requester waits more than NREQ transactions.
REQ-024 rsp_valid and gnt SHALL never be high in the same cycle.

Reset
REQ-025 When rst=1 at a clock edge, the state SHALL become IDLE with gnt=0, rsp_valid=0, rsp_data=0, dut_in=0, busy=0, cnt=0 and ptr=NREQ-1, so requester 0 has first priority.
REQ-026 A reset asserted mid-DRIVE or mid-RESP SHALL abandon the transaction and emit no response.

Structure
REQ-027 Package modul_arb_pkg SHALL hold the state enumeration, the NREQ and HOLD defaults, and the counter width constant (4).
REQ-028 The round-robin search SHALL be a combinational sub-module rr_pick, with inputs req and ptr and output one-hot winner plus index.

Verification
REQ-029 Bench DUT model is an inverter (dut_out = ~dut_in).
REQ-030 Single request: HOLD=2, req=0001, req_in=0001 at t0 -> gnt=0001 at t1..t2, dut_in=1, rsp_valid=0001 with rsp_data=0 at t3.
REQ-031 All four requesting continuously from reset -> grant order 0,1,2,3,0, with each rsp_valid one cycle wide.
REQ-032 Abort: req[2] dropped at the first DRIVE cycle -> gnt=0 next cycle, no rsp_valid, and the next grant goes to requester 3 when both 2 and 3 request.
REQ-033 Reset mid-DRIVE: rst pulsed at t2 -> all outputs 0 at t3, no rsp_valid, and a subsequent req=1111 is granted to requester 0.
REQ-034 HOLD=1, req_in toggled during DRIVE -> dut_in unchanged, rsp_valid exactly 2 cycles after req, and rsp_data equal to the inverse of the latched bit.
